data_mem_responder: RTL and testbench

Memory-side responder for CPU data accesses. It replaces the zero-wait data RAM when the datapath is moved to a request/acknowledge bus. The block accepts one load or store at a time and inserts a programmable number of wait states. It performs byte-lane-masked writes into internal word storage and returns read data with a one-cycle Ack pulse. It flags misaligned and out-of-range addresses with Err.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 156 +++++++++++++++
 tb/tb_data_mem_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/acknowledge data-memory bus between a CPU datapath (master) and
// the memory responder (slave).
interface data_mem_responder_if #(
  parameter int m = 32
);
  logic         Req;
  logic         WE;
  logic [31:0]  Addr;
  logic [m-1:0] WrData;
  logic [3:0]   ByteEn;
  logic         Ack;
  logic [m-1:0] RdData;
  logic         Err;

  modport master (
    output Req, WE, Addr, WrData, ByteEn,
    input  Ack, RdData, Err
  );

  modport slave (
    input  Req, WE, Addr, WrData, ByteEn,
    output Ack, RdData, Err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one access at a time, LATENCY wait states, byte-lane
// writes into 2^n words, single-cycle Ack with Err for rejected addresses.
module data_mem_responder #(
  parameter int n       = 5,
  parameter int m       = 32,
  parameter int LATENCY = 2
) (
  input logic                 Clk,
  input logic                 Reset,
  data_mem_responder_if.slave bus
);

  localparam int         DEPTH    = 1 << n;
  localparam logic [3:0] CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [m-1:0] wr_data_q, wr_data_d;
  logic [3:0]   byte_en_q, byte_en_d;
  logic         ack_q, ack_d;
  logic         err_q, err_d;
  logic [m-1:0] rd_data_q, rd_data_d;
  logic [m-1:0] mem_q [DEPTH];

  logic         op_we;
  logic [31:0]  op_addr;
  logic [m-1:0] op_wr_data;
  logic [3:0]   op_byte_en;
  logic [n-1:0] op_idx;
  logic         op_err;
  logic [m-1:0] merged;
  logic         start_resp;
  logic         mem_we;

  // With zero wait states the access executes on the accepting edge, so the
  // live bus values stand in for the not-yet-latched copies.
  always_comb begin
    if (state_q == IDLE) begin
      op_we      = bus.WE;
      op_addr    = bus.Addr;
      op_wr_data = bus.WrData;
      op_byte_en = bus.ByteEn;
    end else begin
      op_we      = we_q;
      op_addr    = addr_q;
      op_wr_data = wr_data_q;
      op_byte_en = byte_en_q;
    end
  end

  assign op_idx = op_addr[n+1:2];
  assign op_err = (op_addr[1:0] != 2'b00) || ((op_addr >> (n + 2)) != 32'd0);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      merged[8*k +: 8] = op_byte_en[k] ? op_wr_data[8*k +: 8] : mem_q[op_idx][8*k +: 8];
    end
  end

  always_comb begin
    // NOTE: every _d takes its held value first so no path through the case
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    byte_en_d  = byte_en_q;
    rd_data_d  = rd_data_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    start_resp = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Req) begin
          we_d      = bus.WE;
          addr_d    = bus.Addr;
          wr_data_d = bus.WrData;
          byte_en_d = bus.ByteEn;
          if (LATENCY == 0) begin
            state_d    = RESP;
            start_resp = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          start_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The access itself happens on the edge that enters RESP.
    if (start_resp) begin
      ack_d  = 1'b1;
      err_d  = op_err;
      mem_we = op_we && !op_err;
      if (!op_we) begin
        rd_data_d = op_err ? '0 : mem_q[op_idx];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wr_data_q <= '0;
      byte_en_q <= 4'd0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
      // NOTE: storage must read as zero after reset, so the array is built
      // from resettable flops rather than an inferred RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples the
      // pre-edge values; blocking here would create order-dependent races.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      byte_en_q <= byte_en_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
      if (mem_we) begin
        mem_q[op_idx] <= merged;
      end
    end
  end

  assign bus.Ack    = ack_q;
  assign bus.Err    = err_q;
  assign bus.RdData = rd_data_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states and
// one with none, driven from a shared vector table plus hand-written sequences.
module tb_data_mem_responder;

  logic        Clk;
  logic        Reset;
  logic        sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  data_mem_responder_if #(.m(32)) if_l2 ();
  data_mem_responder_if #(.m(32)) if_l0 ();

  assign if_l2.Req    = req & ~sel;
  assign if_l2.WE     = we;
  assign if_l2.Addr   = addr;
  assign if_l2.WrData = wdata;
  assign if_l2.ByteEn = be;
  assign if_l0.Req    = req & sel;
  assign if_l0.WE     = we;
  assign if_l0.Addr   = addr;
  assign if_l0.WrData = wdata;
  assign if_l0.ByteEn = be;

  data_mem_responder #(.n(5), .m(32), .LATENCY(2)) dut_l2 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if_l2.slave)
  );

  data_mem_responder #(.n(5), .m(32), .LATENCY(0)) dut_l0 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if_l0.slave)
  );

  logic        ack;
  logic        err;
  logic [31:0] rdata;
  int          lat;

  assign ack   = sel ? if_l0.Ack    : if_l2.Ack;
  assign err   = sel ? if_l0.Err    : if_l2.Err;
  assign rdata = sel ? if_l0.RdData : if_l2.RdData;
  assign lat   = sel ? 0 : 2;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          scramble;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic do_reset();
    req = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  // Called #1 after an edge with the bus idle; holds Req until Ack is seen.
  task automatic run_vec(input vec_t v);
    int          cycles;
    logic [31:0] rd_seen;
    logic        err_seen;
    req   = 1'b1;
    we    = v.we;
    addr  = v.addr;
    wdata = v.wdata;
    be    = v.be;
    @(posedge Clk); #1;
    if (v.scramble) begin
      we    = ~we;
      addr  = addr ^ 32'h4;
      wdata = ~wdata;
      be    = ~be;
    end
    cycles = 1;
    while (ack !== 1'b1 && cycles <= 20) begin
      @(posedge Clk); #1;
      cycles++;
    end
    rd_seen  = rdata;
    err_seen = err;
    req      = 1'b0;
    check({v.name, " latency"}, 64'(cycles), 64'(lat + 1));
    check({v.name, " rddata"}, 64'(rd_seen), 64'(v.exp_rd));
    check({v.name, " err"}, 64'(err_seen), 64'(v.exp_err));
    @(posedge Clk); #1;
    check({v.name, " ack pulse/hold"}, {30'd0, ack, err, rdata}, {30'd0, 1'b0, 1'b0, v.exp_rd});
  endtask

  // Req held high across Ack: transactions issue every LATENCY+2 cycles.
  task automatic back_to_back(input logic [31:0] exp_rd);
    bit exp_ack;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 32'h10;
    wdata = 32'h0;
    be    = 4'h0;
    for (int k = 0; k < 10; k++) begin
      @(posedge Clk); #1;
      exp_ack = (k >= lat) && (((k - lat) % (lat + 2)) == 0);
      check($sformatf("b2b ack L%0d k%0d", lat, k), 64'(ack), 64'(exp_ack));
      if (exp_ack) begin
        check($sformatf("b2b rddata L%0d k%0d", lat, k), 64'(rdata), 64'(exp_rd));
      end
    end
    req = 1'b0;
    repeat (2 * (lat + 2)) @(posedge Clk);
    #1;
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      run_vec(vecs[i]);
    end
  endtask

  task automatic reset_state_check();
    check($sformatf("reset ack L%0d", lat), 64'(ack), 64'd0);
    check($sformatf("reset err L%0d", lat), 64'(err), 64'd0);
    check($sformatf("reset rddata L%0d", lat), 64'(rdata), 64'd0);
  endtask

  vec_t v;

  initial begin
    Reset = 1'b1;
    sel   = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    be    = 4'h0;

    //            name          we   addr          wdata         be    scr  exp_rd        exp_err
    vecs.push_back('{"st 10 full",  1'b1, 32'h10,       32'h12345678, 4'hF, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{"ld 10",       1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'h12345678, 1'b0});
    vecs.push_back('{"st 10 lanes", 1'b1, 32'h10,       32'hAABBCCDD, 4'h5, 1'b0, 32'h12345678, 1'b0});
    vecs.push_back('{"ld 10 lanes", 1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'h12BB56DD, 1'b0});
    vecs.push_back('{"st 10 be0",   1'b1, 32'h10,       32'hFFFFFFFF, 4'h0, 1'b0, 32'h12BB56DD, 1'b0});
    vecs.push_back('{"ld 10 be0",   1'b0, 32'h10,       32'h0,        4'h0, 1'b0, 32'h12BB56DD, 1'b0});
    vecs.push_back('{"ld 11 mis",   1'b0, 32'h11,       32'h0,        4'h0, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{"st 0",        1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{"st 80 oor",   1'b1, 32'h80,       32'h11111111, 4'hF, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{"ld 0",        1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{"st 7c",       1'b1, 32'h7C,       32'h0BADC0DE, 4'hF, 1'b0, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{"ld 7c",       1'b0, 32'h7C,       32'h0,        4'h0, 1'b0, 32'h0BADC0DE, 1'b0});
    vecs.push_back('{"st 2 mis",    1'b1, 32'h2,        32'h0,        4'hF, 1'b0, 32'h0BADC0DE, 1'b1});
    vecs.push_back('{"ld 0 again",  1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{"ld hi oor",   1'b0, 32'h80000000, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1});
    vecs.push_back('{"st 20 scr",   1'b1, 32'h20,       32'h55AA55AA, 4'h3, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{"ld 24",       1'b0, 32'h24,       32'h0,        4'h0, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{"ld 20 scr",   1'b0, 32'h20,       32'h0,        4'h0, 1'b1, 32'h000055AA, 1'b0});
    vecs.push_back('{"ld 24 again", 1'b0, 32'h24,       32'h0,        4'h0, 1'b0, 32'h0,        1'b0});

    // Two wait states.
    sel = 1'b0;
    do_reset();
    reset_state_check();
    run_table();
    back_to_back(32'h12BB56DD);

    // Reset lands while a store sits in WAIT: the write must never happen.
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h8;
    wdata = 32'hDEADBEEF;
    be    = 4'hF;
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    Reset = 1'b1;
    req   = 1'b0;
    @(posedge Clk); #1;
    check("mid-wait reset outputs", {31'd0, ack, err, rdata}, 64'd0);
    Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk); #1;
      check($sformatf("no ack after reset k%0d", k), 64'(ack), 64'd0);
    end
    v = '{"ld 8 after rst", 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0};
    run_vec(v);
    v = '{"ld 10 cleared", 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0};
    run_vec(v);

    // Zero wait states.
    sel = 1'b1;
    do_reset();
    reset_state_check();
    run_table();
    back_to_back(32'h12BB56DD);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
